// File: rtl/mul_arb_pkg.sv
// Shared constants and types for the multiplier-sharing arbiter.
// Optional feature macro: MUL_ARB_PERF_CNT_EN (performance counters in the top).
package mul_arb_pkg;

   localparam int MUL_A_W  = 55;  // signed operand width (core din0)
   localparam int MUL_B_W  = 24;  // unsigned operand width (core din1)
   localparam int MUL_P_W  = 55;  // product width (core dout, low bits)
   localparam int MUL_LAT  = 4;   // ce-enabled edges from capture to dout
   localparam int MUL_ID_W = 3;   // tag id width, wide enough for 8 requesters

   // One tag travels alongside each operand pair through the core.
   typedef struct packed {
      logic                vld;
      logic [MUL_ID_W-1:0] id;
   } mul_tag_t;

   // Round-robin successor of a granted index.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1) % n;
   endfunction

endpackage

// File: rtl/mul_share_arbiter_if.sv
// Request / response / multiplier-core bus of the multiplier-sharing arbiter.
// Handshake: a request i transfers on a rising clk edge where req_valid[i] & req_ready[i];
// a response transfers on a rising edge where rsp_valid & rsp_ready. A valid, once raised,
// holds its payload stable until it transfers; ready may depend combinationally on valid.
interface mul_share_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int A_W     = 55,
   parameter int B_W     = 24,
   parameter int P_W     = 55,
   parameter int ID_W    = 2
);
   logic [NUM_REQ-1:0]     req_valid;
   logic [NUM_REQ-1:0]     req_ready;
   logic [NUM_REQ*A_W-1:0] req_a;
   logic [NUM_REQ*B_W-1:0] req_b;
   logic                   mul_ce;
   logic [A_W-1:0]         mul_din0;
   logic [B_W-1:0]         mul_din1;
   logic [P_W-1:0]         mul_dout;
   logic                   rsp_valid;
   logic [ID_W-1:0]        rsp_id;
   logic [P_W-1:0]         rsp_data;
   logic                   rsp_ready;

   // Environment side: requesters, response consumer and multiplier core.
   modport master (
      output req_valid, req_a, req_b, mul_dout, rsp_ready,
      input  req_ready, mul_ce, mul_din0, mul_din1, rsp_valid, rsp_id, rsp_data
   );

   // Arbiter side.
   modport slave (
      input  req_valid, req_a, req_b, mul_dout, rsp_ready,
      output req_ready, mul_ce, mul_din0, mul_din1, rsp_valid, rsp_id, rsp_data
   );
endinterface

// File: rtl/mul_arb_rr_picker.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module mul_arb_rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_W-1:0]    ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [ID_W-1:0]    idx_o,
   output logic               any_o
);

   // Scan offsets from farthest to nearest so the nearest set request wins.
   always_comb begin
      int j;
      j       = 0;
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         j = (int'(ptr_i) + k) % NUM_REQ;
         if (req_i[j]) begin
            any_o   = 1'b1;
            idx_o   = ID_W'(j);
            grant_o = NUM_REQ'(1) << j;
         end
      end
   end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one pipelined signed x unsigned multiplier among NUM_REQ requesters.
// Round-robin grant, operand mux, tag pipe matching the core latency, stall on backpressure.
// Optional: `define MUL_ARB_PERF_CNT_EN adds perf_ops / perf_stall counters.
module mul_share_arbiter
   import mul_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 reset,
   mul_share_arbiter_if.slave   bus
`ifdef MUL_ARB_PERF_CNT_EN
   ,
   output logic [31:0]          perf_ops,
   output logic [31:0]          perf_stall
`endif
);

   logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]    last_idx_q, last_idx_d;
   mul_tag_t           tag_q [MUL_LAT];
   mul_tag_t           tag0_d;

   logic [NUM_REQ-1:0] pick_grant;
   logic [ID_W-1:0]    pick_idx;
   logic               pick_any;
   logic               ce;
   logic               accept;
   logic [ID_W-1:0]    sel_idx;
   logic [MUL_ID_W-1:0] tag_id_unused;

   mul_arb_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_picker (
      .req_i   (bus.req_valid),
      .ptr_i   (rr_ptr_q),
      .grant_o (pick_grant),
      .idx_o   (pick_idx),
      .any_o   (pick_any)
   );

   // Core, tag pipe and pointer freeze while a presented response is not taken.
   always_comb begin
      ce            = !(bus.rsp_valid && !bus.rsp_ready);
      accept        = ce && pick_any;
      bus.mul_ce    = ce;
      bus.req_ready = ce ? pick_grant : '0;
   end

   // Operand mux: granted requester, or the last granted one while idle.
   always_comb begin
      sel_idx      = accept ? pick_idx : last_idx_q;
      bus.mul_din0 = bus.req_a[int'(sel_idx)*MUL_A_W +: MUL_A_W];
      bus.mul_din1 = bus.req_b[int'(sel_idx)*MUL_B_W +: MUL_B_W];
   end

   // Next-state for pointer, held index and the tag entering the pipe.
   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      last_idx_d = last_idx_q;
      tag0_d.vld = accept;
      tag0_d.id  = MUL_ID_W'(pick_idx);
      if (accept) begin
         rr_ptr_d   = ID_W'(rr_next(int'(pick_idx), NUM_REQ));
         last_idx_d = pick_idx;
      end
   end

   // State registers; everything advances only on ce-enabled edges.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr_q   <= '0;
         last_idx_q <= '0;
         for (int s = 0; s < MUL_LAT; s++) tag_q[s] <= '0;
      end else if (ce) begin
         rr_ptr_q   <= rr_ptr_d;
         last_idx_q <= last_idx_d;
         tag_q[0]   <= tag0_d;
         for (int s = 1; s < MUL_LAT; s++) tag_q[s] <= tag_q[s-1];
      end
   end

   // Response is the last tag stage plus the core output directly.
   always_comb begin
      bus.rsp_valid = tag_q[MUL_LAT-1].vld;
      bus.rsp_id    = tag_q[MUL_LAT-1].id[ID_W-1:0];
      bus.rsp_data  = bus.mul_dout;
      tag_id_unused = tag_q[MUL_LAT-1].id;
   end

`ifdef MUL_ARB_PERF_CNT_EN
   logic [31:0] perf_ops_q, perf_stall_q;

   // Free-running wrap-around counters of accepts and stalled cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_ops_q   <= '0;
         perf_stall_q <= '0;
      end else begin
         if (accept) perf_ops_q   <= perf_ops_q + 32'd1;
         if (!ce)    perf_stall_q <= perf_stall_q + 32'd1;
      end
   end

   assign perf_ops   = perf_ops_q;
   assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Testbench for mul_share_arbiter with a behavioural 4-stage multiplier core.
module tb_mul_share_arbiter;
   import mul_arb_pkg::*;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;
   localparam int EW      = ID_W + MUL_P_W;

   logic clk;
   logic reset;

   mul_share_arbiter_if #(
      .NUM_REQ (NUM_REQ), .A_W (MUL_A_W), .B_W (MUL_B_W), .P_W (MUL_P_W), .ID_W (ID_W)
   ) bus ();

`ifdef MUL_ARB_PERF_CNT_EN
   logic [31:0] perf_ops, perf_stall;
`endif

   mul_share_arbiter #(.NUM_REQ (NUM_REQ), .ID_W (ID_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus.slave)
`ifdef MUL_ARB_PERF_CNT_EN
      ,
      .perf_ops   (perf_ops),
      .perf_stall (perf_stall)
`endif
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- multiplier core model (no reset) ----------------
   logic [MUL_P_W-1:0]           core_s [MUL_LAT];
   logic signed [MUL_A_W+MUL_B_W:0] core_full;
   always_comb core_full = $signed(bus.mul_din0) * $signed({1'b0, bus.mul_din1});
   always @(posedge clk) begin
      if (bus.mul_ce) begin
         core_s[0] <= core_full[MUL_P_W-1:0];
         for (int s = 1; s < MUL_LAT; s++) core_s[s] <= core_s[s-1];
      end
   end
   assign bus.mul_dout = core_s[MUL_LAT-1];

   // ---------------- scoreboard ----------------
   logic [EW-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every transferred response is compared with the head of the queue.
   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (!reset && bus.rsp_valid && bus.rsp_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: id=%0d data=0x%0h with empty queue", bus.rsp_id, bus.rsp_data);
         end else begin
            e = exp_q.pop_front();
            chk("rsp_id", 64'(bus.rsp_id), 64'(e[EW-1 -: ID_W]));
            chk("rsp_data", 64'(bus.rsp_data), 64'(e[MUL_P_W-1:0]));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_op(input int i, input logic [MUL_A_W-1:0] a, input logic [MUL_B_W-1:0] b);
      bus.req_a[i*MUL_A_W +: MUL_A_W] = a;
      bus.req_b[i*MUL_B_W +: MUL_B_W] = b;
   endtask

   task automatic push_exp(input logic [ID_W-1:0] id, input logic [MUL_P_W-1:0] p);
      exp_q.push_back({id, p});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.req_valid = '0;
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         step();
         n++;
      end
      chk(name, 64'(exp_q.size()), 64'd0);
   endtask

   // Hand-computed directed vectors (55-bit products).
   logic [MUL_A_W-1:0] a_tab [NUM_REQ];
   logic [MUL_B_W-1:0] b_tab [NUM_REQ];
   logic [MUL_P_W-1:0] p_tab [NUM_REQ];

   initial begin
      logic [ID_W-1:0]    held_id;
      logic [MUL_P_W-1:0] held_data;
      int seen;

      a_tab[0] = 55'sd7;     b_tab[0] = 24'd3;  p_tab[0] = 55'sd21;
      a_tab[1] = -55'sd2;    b_tab[1] = 24'd9;  p_tab[1] = -55'sd18;
      a_tab[2] = 55'sd100;   b_tab[2] = 24'd50; p_tab[2] = 55'sd5000;
      a_tab[3] = -55'sd1000; b_tab[3] = 24'd2;  p_tab[3] = -55'sd2000;

      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b1;
      reset         = 1'b1;
      step();
      step();

      // Reset state.
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
      chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
      chk("rst_mul_ce", 64'(bus.mul_ce), 64'd1);
      reset = 1'b0;
      step();

      // Single request: -3 * 5 = -15, visible four cycles later.
      set_op(0, -55'sd3, 24'd5);
      bus.req_valid = 4'b0001;
      #1;
      chk("single_grant", 64'(bus.req_ready), 64'h1);
      push_exp(2'd0, -55'sd15);
      step();
      bus.req_valid = '0;
      step();
      chk("single_lat1", 64'(bus.rsp_valid), 64'd0);
      step();
      chk("single_lat2", 64'(bus.rsp_valid), 64'd0);
      step();
      chk("single_lat3", 64'(bus.rsp_valid), 64'd1);
      drain("single_drain");

      // All four requesters valid: grants 0,1,2,3,0,1,2,3.
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) set_op(i, a_tab[i], b_tab[i]);
      bus.req_valid = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         #1;
         chk("rr_grant", 64'(bus.req_ready), 64'(4'b0001 << (k % NUM_REQ)));
         push_exp(ID_W'(k % NUM_REQ), p_tab[k % NUM_REQ]);
         @(posedge clk);
      end
      #1;
      bus.req_valid = '0;

      // Backpressure for three cycles while a response is presented.
      chk("stall_rsp_present", 64'(bus.rsp_valid), 64'd1);
      bus.rsp_ready = 1'b0;
      bus.req_valid = 4'b0011;
      held_id   = bus.rsp_id;
      held_data = bus.rsp_data;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("stall_ce", 64'(bus.mul_ce), 64'd0);
         chk("stall_req_ready", 64'(bus.req_ready), 64'd0);
         chk("stall_valid_held", 64'(bus.rsp_valid), 64'd1);
         chk("stall_id_held", 64'(bus.rsp_id), 64'(held_id));
         chk("stall_data_held", 64'(bus.rsp_data), 64'(held_data));
      end
      bus.rsp_ready = 1'b1;
      push_exp(2'd0, p_tab[0]);
      push_exp(2'd1, p_tab[1]);
      step();
      bus.req_valid = 4'b0010;
      step();
      bus.req_valid = '0;
      drain("stall_drain");
`ifdef MUL_ARB_PERF_CNT_EN
      chk("perf_ops", 64'(perf_ops), 64'd10);
      chk("perf_stall", 64'(perf_stall), 64'd3);
`endif

      // Boundary operands on requesters 2 and 3.
      do_reset();
      set_op(2, 55'h3F_FFFF_FFFF_FFFF, 24'hFF_FFFF);
      set_op(3, 55'h40_0000_0000_0000, 24'd1);
      bus.req_valid = 4'b1100;
      #1;
      chk("bound_grant2", 64'(bus.req_ready), 64'h4);
      push_exp(2'd2, 55'h3F_FFFF_FF00_0001);
      push_exp(2'd3, 55'h40_0000_0000_0000);
      step();
      bus.req_valid = 4'b1000;
      chk("bound_grant3", 64'(bus.req_ready), 64'h8);
      step();
      bus.req_valid = '0;
      drain("bound_drain");

      // Reset with ops in flight: nothing from before the reset may emerge.
      do_reset();
      bus.rsp_ready = 1'b0;
      bus.req_valid = 4'b1111;
      for (int k = 0; k < 4; k++) step();
      bus.req_valid = '0;
      chk("inflight_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      reset = 1'b1;
      #1;
      chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("midrst_mul_ce", 64'(bus.mul_ce), 64'd1);
      bus.rsp_ready = 1'b1;
      step();
      step();
      reset = 1'b0;
      seen = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (bus.rsp_valid) seen++;
      end
      chk("midrst_no_stale", 64'(seen), 64'd0);
      chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global time bound.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, errors so far %0d", errors);
      $fatal(1, "timeout");
   end

endmodule
